config_loader: RTL
==================

# config_loader

Bitstream configuration loader that sits directly upstream of a logic cluster's serial programming chain. It accepts configuration bytes over a valid/ready handshake and serializes them onto the chain as `prog_data`, `prog_clk` and `prog_en`. It counts exactly `CHAIN_LEN` bits, then signals completion. The cluster's chain is a plain shift register, so this block owns all bit ordering, clock shaping and framing.

## Interface
- `CHAIN_LEN`, 80: total configuration bits in the downstream chain (≥1).
- `CLK_DIV`, 2: `clk` cycles per `prog_clk` phase (≥1); one bit = 2·`CLK_DIV` cycles.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `data_in`  in  8  configuration byte.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  block can accept a byte this cycle.
- `prog_data`  out  1  serial bit to the chain's `prog_in`.
- `prog_clk`  out  1  chain shift clock.
- `prog_en`  out  1  chain shift enable.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse at the end of a load.
- `error`  out  1  CRC mismatch on the last load; tied 0 when CRC is compiled out.

## Operation
- States: IDLE, WAIT_BYTE, SHIFT_LO, SHIFT_HI, WAIT_CRC (CRC builds only), DONE.
- IDLE:
  - `start` moves to WAIT_BYTE and clears `error`.
  - `start` in any other state is ignored.
- WAIT_BYTE:
  - `data_ready`=1; a byte is accepted when `data_valid && data_ready`.
  - An accepted byte is loaded into the shift register and the state moves to SHIFT_LO.
- SHIFT_LO:
  - `prog_clk`=0, `prog_data` = current bit.
  - Lasts `CLK_DIV` cycles, then moves to SHIFT_HI.
- SHIFT_HI:
  - `prog_clk`=1, `prog_data` held; the chain samples on this rising edge.
  - Lasts `CLK_DIV` cycles, then goes to the next state:
    - more bits in the byte and total < `CHAIN_LEN` → SHIFT_LO;
    - byte exhausted and total < `CHAIN_LEN` → WAIT_BYTE;
    - total = `CHAIN_LEN` → DONE, or WAIT_CRC when CRC is enabled.
- Bit order:
  - Bytes are sent LSB first, byte 0 first.
  - The first bit sent ends at the far end of the chain.
  - Bytes needed = ceil(`CHAIN_LEN`/8). Unused high bits of the final byte are discarded and never shifted.
- `prog_en`:
  - Rises on entry to the first SHIFT_LO.
  - Stays 1 through inter-byte WAIT_BYTE stalls, with `prog_clk` held 0 while stalled.
  - Falls on entry to DONE or WAIT_CRC.
- DONE: `done`=1 for one cycle, then IDLE.
- Bit counter width is $clog2(`CHAIN_LEN`+1) and it never wraps. The phase divider counts 0..`CLK_DIV`-1.

## Timing
- Reset values: `data_ready`, `prog_data`, `prog_clk`, `prog_en`, `busy`, `done`, `error` all 0; state IDLE.
- All outputs are registered.
- `start` sampled at edge t → WAIT_BYTE, `busy`=1 and `data_ready`=1 from cycle t+1.
- Byte accepted at edge a → `prog_en`=1 and first bit valid from cycle a+1. `prog_data` changes only while `prog_clk` is 0.
- Streaming with `data_valid` held high costs 1 WAIT_BYTE cycle per byte. Load length = `CHAIN_LEN`·2·`CLK_DIV` + bytes cycles (+1 for the CRC byte in CRC builds), then 1 cycle of DONE.
- `busy`=1 from WAIT_BYTE through the last cycle before DONE; `busy`=0 in DONE.
- Reset mid-load: on the next edge every output returns to its reset value and the state returns to IDLE. The chain contents are then undefined and a full reload is required.

## Configuration
- `CONFIG_LOADER_CRC_EN` defined:
  - CRC-8 (polynomial 0x07, init 0x00) runs over every accepted payload byte, padding bits included, processed MSB first.
  - After the last bit, WAIT_CRC asserts `data_ready` and accepts one trailer byte.
  - `error`=1 if the trailer ≠ CRC; the state then moves to DONE.
  - `error` holds until the next accepted `start` or reset.
- Not defined: no WAIT_CRC state, no trailer byte, `error` constant 0.

## Structure
- Shared package `config_pkg`: state enum and the `CRC8_POLY` constant (8'h07).
- One sub-module, `config_crc8`: combinational byte-wide CRC-8 update (crc_in, byte → crc_out). It is instantiated only when `CONFIG_LOADER_CRC_EN` is defined.

## Test plan
- Basic load (`CHAIN_LEN`=12, `CLK_DIV`=1): `start`, then bytes 0xA5, 0x03 with `data_valid` held → `prog_data` at each `prog_clk` rise is 1,0,1,0,0,1,0,1,1,1,0,0; exactly 12 rises; one `done` pulse; `prog_en` falls with `done`.
- Stall (same parameters): withhold byte 1 for 10 cycles → `prog_en` stays 1 and `prog_clk` stays 0 during the stall; bit sequence unchanged.
- `CLK_DIV`=3: each `prog_clk` phase lasts exactly 3 cycles; `prog_data` never changes while `prog_clk`=1.
- Reset and ignored start: assert `rst_n`=0 after the 5th bit → next cycle all outputs 0 and state IDLE. A `start` pulse while `busy`=1 has no effect.
- CRC build (`CONFIG_LOADER_CRC_EN`, `CHAIN_LEN`=12): payload 0xA5, 0x03 with trailer 0x50 → `done`=1, `error`=0. Trailer 0x51 → `error`=1, held until the next `start`.

Source files
------------

// File: rtl/config_pkg.sv
// Shared types for the configuration loader: FSM state encoding and CRC-8 polynomial.
package config_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT_LO,
        SHIFT_HI,
        WAIT_CRC,
        DONE
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/config_crc8.sv
// Combinational byte-wide CRC-8 update; message bits are folded in MSB first.
module config_crc8
    import config_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] stage [0:8];

    assign stage[0] = crc_in ^ byte_in;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign stage[gi+1] = stage[gi][7] ? ({stage[gi][6:0], 1'b0} ^ CRC8_POLY)
                                              : {stage[gi][6:0], 1'b0};
        end
    endgenerate

    assign crc_out = stage[8];

endmodule

// File: rtl/config_loader.sv
// Serial chain loader: bytes in over valid/ready, LSB-first bit stream out on prog_data/prog_clk/prog_en.
// Trailer CRC-8 check is compiled in when CONFIG_LOADER_CRC_EN is defined.
module config_loader
    import config_pkg::*;
#(
    parameter int CHAIN_LEN = 80,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       prog_data,
    output logic       prog_clk,
    output logic       prog_en,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(CHAIN_LEN);
    localparam logic [DW-1:0] PHASE_END = DW'(CLK_DIV - 1);

    state_e        state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] phase_q, phase_d;
    logic          data_ready_q, data_ready_d;
    logic          prog_data_q, prog_data_d;
    logic          prog_clk_q, prog_clk_d;
    logic          prog_en_q, prog_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          phase_end;
    logic          accept;
    logic [CW-1:0] cnt_inc;

    assign phase_end = (phase_q == PHASE_END);
    assign accept    = data_valid && data_ready_q;
    assign cnt_inc   = bit_cnt_q + CW'(1);

`ifdef CONFIG_LOADER_CRC_EN
    logic [7:0] crc_q, crc_d, crc_upd;
    logic       error_q, error_d;

    config_crc8 u_crc8 (
        .crc_in  (crc_q),
        .byte_in (data_in),
        .crc_out (crc_upd)
    );

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign data_ready = data_ready_q;
    assign prog_data  = prog_data_q;
    assign prog_clk   = prog_clk_q;
    assign prog_en    = prog_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            bit_cnt_q    <= '0;
            phase_q      <= '0;
            data_ready_q <= 1'b0;
            prog_data_q  <= 1'b0;
            prog_clk_q   <= 1'b0;
            prog_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            crc_q        <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            phase_q      <= phase_d;
            data_ready_q <= data_ready_d;
            prog_data_q  <= prog_data_d;
            prog_clk_q   <= prog_clk_d;
            prog_en_q    <= prog_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef CONFIG_LOADER_CRC_EN
            crc_q        <= crc_d;
            error_q      <= error_d;
`endif
        end
    end

    // Outputs are computed for the state being entered so every port comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        bit_cnt_d    = bit_cnt_q;
        phase_d      = phase_q;
        data_ready_d = data_ready_q;
        prog_data_d  = prog_data_q;
        prog_clk_d   = prog_clk_q;
        prog_en_d    = prog_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
        crc_d        = crc_q;
        error_d      = error_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = WAIT_BYTE;
                    busy_d       = 1'b1;
                    data_ready_d = 1'b1;
                    bit_cnt_d    = '0;
`ifdef CONFIG_LOADER_CRC_EN
                    crc_d        = '0;
                    error_d      = 1'b0;
`endif
                end
            end

            WAIT_BYTE: begin
                if (accept) begin
                    state_d      = SHIFT_LO;
                    shreg_d      = data_in;
                    bit_idx_d    = '0;
                    phase_d      = '0;
                    data_ready_d = 1'b0;
                    prog_en_d    = 1'b1;
                    prog_clk_d   = 1'b0;
                    prog_data_d  = data_in[0];
`ifdef CONFIG_LOADER_CRC_EN
                    crc_d        = crc_upd;
`endif
                end
            end

            SHIFT_LO: begin
                if (phase_end) begin
                    state_d    = SHIFT_HI;
                    phase_d    = '0;
                    prog_clk_d = 1'b1;
                end else begin
                    phase_d = phase_q + DW'(1);
                end
            end

            SHIFT_HI: begin
                if (phase_end) begin
                    phase_d    = '0;
                    prog_clk_d = 1'b0;
                    bit_cnt_d  = cnt_inc;
                    if (cnt_inc == LAST_CNT) begin
                        // Remaining high bits of a partial final byte are dropped here.
                        prog_en_d   = 1'b0;
                        prog_data_d = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
                        state_d      = WAIT_CRC;
                        data_ready_d = 1'b1;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
`endif
                    end else if (bit_idx_q == 3'd7) begin
                        state_d      = WAIT_BYTE;
                        data_ready_d = 1'b1;
                    end else begin
                        state_d     = SHIFT_LO;
                        bit_idx_d   = bit_idx_q + 3'd1;
                        shreg_d     = {1'b0, shreg_q[7:1]};
                        prog_data_d = shreg_q[1];
                    end
                end else begin
                    phase_d = phase_q + DW'(1);
                end
            end

`ifdef CONFIG_LOADER_CRC_EN
            WAIT_CRC: begin
                if (accept) begin
                    state_d      = DONE;
                    data_ready_d = 1'b0;
                    error_d      = (data_in != crc_q);
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
